// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with a fixed WIDTH+1 cycle latency.
// Operands are sign-normalised at accept, and the sign is restored on the final cycle.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dz
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);

    localparam logic [2:0] OpMul   = 3'd0;
    localparam logic [2:0] OpMulh  = 3'd1;
    localparam logic [2:0] OpMulhu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpRem   = 3'd5;
    localparam logic [2:0] OpRemu  = 3'd6;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic                 dz_q, dz_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_result_q, out_result_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic                 out_dz_q, out_dz_d;

    logic                 accept;
    logic                 is_signed_in, is_mul_in, is_div_in;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 is_mul_q;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic [WIDTH-1:0]     result_sel;

    // Operand conditioning at accept.
    always_comb begin
        is_signed_in = (in_op == OpMulh) || (in_op == OpDiv) || (in_op == OpRem);
        is_mul_in    = (in_op == OpMul) || (in_op == OpMulh) || (in_op == OpMulhu);
        is_div_in    = (in_op == OpDiv) || (in_op == OpDivu) ||
                       (in_op == OpRem) || (in_op == OpRemu);
        a_neg        = is_signed_in & in_a[WIDTH-1];
        b_neg        = is_signed_in & in_b[WIDTH-1];
        a_mag        = a_neg ? -in_a : in_a;
        b_mag        = b_neg ? -in_b : in_b;
        in_ready     = rst_n && !flush &&
                       ((state_q == StIdle) || ((state_q == StDone) && out_ready));
        accept       = in_valid && in_ready;
    end

    // Per-step datapath and final sign fix.
    always_comb begin
        is_mul_q  = (op_q == OpMul) || (op_q == OpMulh) || (op_q == OpMulhu);
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, m_q};
        div_ge    = ~div_diff[WIDTH];
        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OpMul:           result_sel = prod_fix[WIDTH-1:0];
            OpMulh, OpMulhu: result_sel = prod_fix[2*WIDTH-1:WIDTH];
            OpDiv, OpDivu:   result_sel = dz_q ? '1 : quo_fix;
            OpRem, OpRemu:   result_sel = rem_fix;
            default:         result_sel = '1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        neg_d        = neg_q;
        dz_d         = dz_q;
        tag_d        = tag_q;
        m_d          = m_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_dz_d     = out_dz_q;

        case (state_q)
            StCalc: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                    if (is_mul_q) begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                                 acc_q[WIDTH-2:0], div_ge};
                    end
                end else begin
                    state_d      = StDone;
                    out_valid_d  = 1'b1;
                    out_result_d = result_sel;
                    out_tag_d    = tag_q;
                    out_dz_d     = dz_q;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
        if (accept) begin
            state_d = StCalc;
            cnt_d   = CntInit;
            op_d    = in_op;
            neg_d   = (in_op == OpRem) ? a_neg : (a_neg ^ b_neg);
            dz_d    = is_div_in && (in_b == '0);
            tag_d   = in_tag;
            m_d     = is_mul_in ? a_mag : b_mag;
            acc_d   = {{WIDTH{1'b0}}, (is_mul_in ? b_mag : a_mag)};
        end

        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            dz_q         <= 1'b0;
            tag_q        <= '0;
            m_q          <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_dz_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            dz_q         <= dz_d;
            tag_q        <= tag_d;
            m_q          <= m_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_dz_q     <= out_dz_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_dz     = out_dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written backpressure/flush/reset sequences.
module tb_mul_div_unit;

    localparam int W  = 32;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [TW-1:0] out_tag;
    logic          out_dz;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_dz     (out_dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         dz;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference model: plain 64-bit / int arithmetic with the architectural special cases.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [63:0] up;
        longint      sp;
        int          sa, sb, sr;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return {1'b0, up[31:0]}; end
            3'd1: begin sp = longint'(sa) * longint'(sb); up = sp; return {1'b0, up[63:32]}; end
            3'd2: begin up = {32'b0, a} * {32'b0, b}; return {1'b0, up[63:32]}; end
            3'd3: begin
                if (b == 0) return {1'b1, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
                sr = sa / sb;
                return {1'b0, sr};
            end
            3'd4: begin
                if (b == 0) return {1'b1, 32'hFFFF_FFFF};
                return {1'b0, a / b};
            end
            3'd5: begin
                if (b == 0) return {1'b1, a};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0};
                sr = sa % sb;
                return {1'b0, sr};
            end
            3'd6: begin
                if (b == 0) return {1'b1, a};
                return {1'b0, a % b};
            end
            default: return {1'b0, 32'hFFFF_FFFF};
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout_fail("accept");
        @(posedge clk);
        #1;
        // Later operand changes must not affect the in-flight operation.
        in_valid = 1'b0;
        in_op    = 3'($urandom_range(0, 7));
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = TW'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) timeout_fail("result_wait");
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] tag,
                          input logic [W-1:0] exp_res, input logic exp_dz);
        int lat;
        issue(op, a, b, tag);
        wait_result(lat);
        chk({name, "_lat"}, 64'(lat), 64'(W + 1));
        chk({name, "_res"}, 64'(out_result), 64'(exp_res));
        chk({name, "_dz"}, 64'(out_dz), 64'(exp_dz));
        chk({name, "_tag"}, 64'(out_tag), 64'(tag));
        @(posedge clk);
        #1;
        chk({name, "_drop"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          bad;
        bit          seen;
        logic [2:0]  rop;
        logic [W-1:0] ra, rb;
        logic [32:0] exp;

        tbl[0]  = '{op: 3'd0, a: 32'h0000_0007, b: 32'hFFFF_FFFD, res: 32'hFFFF_FFEB, dz: 1'b0};
        tbl[1]  = '{op: 3'd1, a: 32'h8000_0000, b: 32'h8000_0000, res: 32'h4000_0000, dz: 1'b0};
        tbl[2]  = '{op: 3'd2, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'hFFFF_FFFE, dz: 1'b0};
        tbl[3]  = '{op: 3'd0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'h0000_0001, dz: 1'b0};
        tbl[4]  = '{op: 3'd3, a: 32'hFFFF_FFF9, b: 32'h0000_0002, res: 32'hFFFF_FFFD, dz: 1'b0};
        tbl[5]  = '{op: 3'd5, a: 32'hFFFF_FFF9, b: 32'h0000_0002, res: 32'hFFFF_FFFF, dz: 1'b0};
        tbl[6]  = '{op: 3'd4, a: 32'd100, b: 32'd7, res: 32'd14, dz: 1'b0};
        tbl[7]  = '{op: 3'd6, a: 32'd100, b: 32'd7, res: 32'd2, dz: 1'b0};
        tbl[8]  = '{op: 3'd3, a: 32'h8000_0000, b: 32'hFFFF_FFFF, res: 32'h8000_0000, dz: 1'b0};
        tbl[9]  = '{op: 3'd5, a: 32'h8000_0000, b: 32'hFFFF_FFFF, res: 32'h0000_0000, dz: 1'b0};
        tbl[10] = '{op: 3'd3, a: 32'd5, b: 32'd0, res: 32'hFFFF_FFFF, dz: 1'b1};
        tbl[11] = '{op: 3'd6, a: 32'd5, b: 32'd0, res: 32'd5, dz: 1'b1};
        tbl[12] = '{op: 3'd7, a: 32'd1, b: 32'd2, res: 32'hFFFF_FFFF, dz: 1'b0};
        tbl[13] = '{op: 3'd5, a: 32'hFFFF_FFF9, b: 32'd0, res: 32'hFFFF_FFF9, dz: 1'b1};
        tbl[14] = '{op: 3'd3, a: 32'hFFFF_FFF9, b: 32'd0, res: 32'hFFFF_FFFF, dz: 1'b1};
        tbl[15] = '{op: 3'd1, a: 32'hFFFF_FFFF, b: 32'd7, res: 32'hFFFF_FFFF, dz: 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(out_result), 64'(0));
        chk("rst_tag", 64'(out_tag), 64'(0));
        chk("rst_dz", 64'(out_dz), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, TW'(i + 9),
                   tbl[i].res, tbl[i].dz);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) rb = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            exp = model(rop, ra, rb);
            run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, TW'($urandom), exp[31:0],
                   exp[32]);
        end

        // Backpressure in DONE, then handshake with a same-cycle accept.
        @(negedge clk);
        out_ready = 1'b0;
        issue(3'd4, 32'd100, 32'd7, 5'd3);
        wait_result(lat);
        chk("bp_lat", 64'(lat), 64'(W + 1));
        @(negedge clk);
        in_op    = 3'd2;
        in_a     = 32'hFFFF_FFFF;
        in_b     = 32'hFFFF_FFFF;
        in_tag   = 5'd5;
        in_valid = 1'b1;
        bad      = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!out_valid || out_result != 32'd14 || out_tag != 5'd3 || in_ready) bad++;
        end
        chk("bp_hold_bad_cycles", 64'(bad), 64'(0));
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        chk("bp_drop", 64'(out_valid), 64'(0));
        // wait_result counts from the following edge; the accept edge is the one just passed.
        wait_result(lat);
        chk("b2b_lat", 64'(lat), 64'(W + 1));
        chk("b2b_res", 64'(out_result), 64'(32'hFFFF_FFFE));
        chk("b2b_tag", 64'(out_tag), 64'(5));
        @(posedge clk);

        // Flush partway through CALC, with a competing offer that must be blocked.
        issue(3'd0, 32'd3, 32'd5, 5'd7);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_a     = 32'd2;
        in_b     = 32'd2;
        #1;
        chk("flush_blocks_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_idle_ready", 64'(in_ready), 64'(1));
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", 64'(seen), 64'(0));
        chk("flush_keeps_result", 64'(out_result), 64'(32'hFFFF_FFFE));

        // Asynchronous reset mid-operation.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_result", 64'(out_result), 64'(0));
        chk("mid_rst_tag", 64'(out_tag), 64'(0));
        chk("mid_rst_dz", 64'(out_dz), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        run_op("post_rst_mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit that extends the single-cycle execute stage with MUL/MULH/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the ALU. The execute stage issues through a valid/ready handshake and stalls until the tagged result returns for register write-back.
- Fixed, data-independent latency. One operation in flight.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
TAG_W, 5, width of destination-register tag carried with the operation (matches wra)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of the in-flight operation
in_valid  input  1  operation offered
in_ready  output  1  unit accepts operation this cycle
in_op  input  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved
in_a  input  WIDTH  operand1 (reg1, dividend)
in_b  input  WIDTH  operand2 (reg2, divisor)
in_tag  input  TAG_W  destination register address
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_result  output  WIDTH  result word
out_tag  output  TAG_W  tag captured at accept
out_dz  output  1  divide-by-zero flag (DIV/DIVU/REM/REMU with in_b==0)

Behaviour:
- Reset is asynchronous and active-low. Clock port is clk; reset port is rst_n. While rst_n=0: state IDLE; out_valid, out_result, out_tag, out_dz all 0; in_ready=0. Reset mid-operation discards all work.
- States: IDLE -> CALC -> DONE.
- in_ready = !flush && (IDLE || (DONE && out_ready)).
- Accept when in_valid && in_ready: latch op, tag, operands. Convert signed operands to magnitudes plus a result-sign bit. Counter = WIDTH. Go to CALC.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing WIDTH-bit quotient and remainder.
  - Counter decrements each cycle; on the cycle it reaches 0, the next edge does the sign fix and moves to DONE.
- Latency: out_valid rises exactly WIDTH+1 rising edges after the accept edge (33 for WIDTH=32), for every op and operand value, including divide by zero.
- Result selection:
  - MUL: low WIDTH bits of the product (identical signed/unsigned).
  - MULH: high WIDTH bits, signed x signed. MULHU: high WIDTH bits, unsigned x unsigned.
  - DIV/DIVU: quotient truncated toward zero. REM/REMU: remainder, which takes the sign of the dividend.
  - Reserved op 7: result all-ones, out_dz=0, normal latency.
- Divide by zero: quotient all-ones (signed and unsigned), remainder = in_a unmodified, out_dz=1. out_dz=0 for all multiplies.
- Signed overflow: DIV of most-negative by -1 gives most-negative; REM gives 0; out_dz=0.
- DONE: out_valid=1. out_result, out_tag and out_dz are held stable until out_valid && out_ready.
  - On handshake without a new accept, go to IDLE; out_valid drops next edge.
  - On handshake with a same-cycle accept, go directly to CALC (back-to-back, no bubble).
- out_result, out_tag and out_dz keep their last values in IDLE and CALC; only out_valid qualifies them.
- flush=1 in any state: go to IDLE at the next edge, out_valid=0, any result discarded. flush blocks acceptance in the same cycle.
- Operands are sampled only at accept; changes to in_a, in_b or in_op afterwards have no effect.

Test Plan:
- MUL in_a=7, in_b=0xFFFFFFFD, tag=9 -> out_result=0xFFFFFFEB, out_tag=9, out_valid high exactly 33 edges after accept.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MUL of the same operands -> 0x00000001.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- DIV 5/0 -> 0xFFFFFFFF with out_dz=1. REMU 5/0 -> 5 with out_dz=1. Both still take 33 edges.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result and tag stable, in_ready=0. Then out_ready=1 with in_valid=1 -> next op accepted on the same edge, its result 33 edges later.
- flush asserted at CALC cycle 12 -> IDLE next edge, no out_valid. rst_n low at cycle 20 of a later op -> all outputs 0 immediately; after release in_ready=1 and a fresh MUL completes correctly.
